// File: rtl/csr_access_ctrl_if.sv
// Bundle of request, response, redirect and regfile signals for csr_access_ctrl.
// Handshake: a request (ins/trap/mret) transfers on a posedge where valid && ready; valid must hold until then.
interface csr_access_ctrl_if;
  logic        ins_valid;
  logic        ins_ready;
  logic [2:0]  ins_op;
  logic [11:0] ins_addr;
  logic [31:0] ins_src;
  logic        ins_src_zero;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        trap_valid;
  logic        trap_ready;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        mret_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        csr_write_en;
  logic [11:0] csr_write_addr;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_data_write;
  logic [31:0] csr_data_read;
  logic [2:0]  dbg_state;

  modport slave (
    input  ins_valid, ins_op, ins_addr, ins_src, ins_src_zero,
    input  trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    input  csr_data_read,
    output ins_ready, rsp_valid, rsp_rdata, rsp_illegal,
    output trap_ready, mret_ready, redir_valid, redir_pc,
    output csr_write_en, csr_write_addr, csr_read_addr, csr_data_write,
    output dbg_state
  );

  modport master (
    output ins_valid, ins_op, ins_addr, ins_src, ins_src_zero,
    output trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    output csr_data_read,
    input  ins_ready, rsp_valid, rsp_rdata, rsp_illegal,
    input  trap_ready, mret_ready, redir_valid, redir_pc,
    input  csr_write_en, csr_write_addr, csr_read_addr, csr_data_write,
    input  dbg_state
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Serialises CSR instructions, trap entry and mret onto a single-port CSR regfile.
// Define CSR_MTVAL_EN to add the mtval save step to the trap sequence.
module csr_access_ctrl #(
  parameter logic [11:0] ADDR_MEPC   = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE = 12'h342,
  parameter logic [11:0] ADDR_MTVEC  = 12'h305,
  parameter logic [11:0] ADDR_MTVAL  = 12'h343
) (
  input logic clk,
  input logic rst,
  csr_access_ctrl_if.slave bus
);

`ifdef CSR_MTVAL_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, I_RD = 3'd1, I_WR = 3'd2, T_EPC = 3'd3,
    T_CAUSE = 3'd4, T_TVAL = 3'd5, T_VEC = 3'd6, M_RD = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, I_RD = 3'd1, I_WR = 3'd2, T_EPC = 3'd3,
    T_CAUSE = 3'd4, T_VEC = 3'd6, M_RD = 3'd7
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q;
  logic        zero_q;
  logic [31:0] old_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
`ifdef CSR_MTVAL_EN
  logic [31:0] tval_q;
`else
  logic        unused_tval;
  assign unused_tval = ^bus.trap_tval;
`endif

  logic        idle_live;
  logic        trap_acc, mret_acc, ins_acc;
  logic        illegal;
  logic [31:0] new_val;
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  // Readies are also held low while rst is asserted so nothing is accepted into a resetting FSM.
  assign idle_live = (state_q == IDLE) && rst;
  assign trap_acc  = idle_live && bus.trap_valid;
  assign mret_acc  = idle_live && !bus.trap_valid && bus.mret_valid;
  assign ins_acc   = idle_live && !bus.trap_valid && !bus.mret_valid && bus.ins_valid;

  assign illegal = (op_q[1:0] == 2'b00);

  always_comb begin
    new_val = '0;
    case (op_q[1:0])
      2'b01:   new_val = src_q;
      2'b10:   new_val = old_q | src_q;
      2'b11:   new_val = old_q & ~src_q;
      default: new_val = '0;
    endcase
  end

  // Vectored mode only applies to interrupts (cause[31] set).
  assign vec_base   = {bus.csr_data_read[31:2], 2'b00};
  assign vec_target = ((bus.csr_data_read[1:0] == 2'b01) && cause_q[31])
                      ? vec_base + {cause_q[29:0], 2'b00} : vec_base;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      zero_q  <= 1'b0;
      old_q   <= '0;
      pc_q    <= '0;
      cause_q <= '0;
`ifdef CSR_MTVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (ins_acc) begin
        op_q   <= bus.ins_op;
        addr_q <= bus.ins_addr;
        src_q  <= bus.ins_src;
        zero_q <= bus.ins_src_zero;
      end
      if (trap_acc) begin
        pc_q    <= bus.trap_pc;
        cause_q <= bus.trap_cause;
`ifdef CSR_MTVAL_EN
        tval_q  <= bus.trap_tval;
`endif
      end
      if (state_q == I_RD) old_q <= bus.csr_data_read;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.ins_ready      = 1'b0;
    bus.trap_ready     = 1'b0;
    bus.mret_ready     = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_rdata      = '0;
    bus.rsp_illegal    = 1'b0;
    bus.redir_valid    = 1'b0;
    bus.redir_pc       = '0;
    bus.csr_write_en   = 1'b0;
    bus.csr_write_addr = '0;
    bus.csr_read_addr  = '0;
    bus.csr_data_write = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          bus.trap_ready = 1'b1;
          bus.mret_ready = !bus.trap_valid;
          bus.ins_ready  = !bus.trap_valid && !bus.mret_valid;
          if (bus.trap_valid)      state_d = T_EPC;
          else if (bus.mret_valid) state_d = M_RD;
          else if (bus.ins_valid)  state_d = I_RD;
        end
        I_RD: begin
          bus.csr_read_addr = addr_q;
          state_d           = I_WR;
        end
        I_WR: begin
          bus.rsp_valid   = 1'b1;
          bus.rsp_illegal = illegal;
          bus.rsp_rdata   = illegal ? '0 : old_q;
          // Set/clear with a zero operand must not write (read-only CSRs stay silent).
          if (!illegal && !(op_q[1] && zero_q)) begin
            bus.csr_write_en   = 1'b1;
            bus.csr_write_addr = addr_q;
            bus.csr_data_write = new_val;
          end
          state_d = IDLE;
        end
        T_EPC: begin
          bus.csr_write_en   = 1'b1;
          bus.csr_write_addr = ADDR_MEPC;
          bus.csr_data_write = {pc_q[31:2], 2'b00};
          state_d            = T_CAUSE;
        end
        T_CAUSE: begin
          bus.csr_write_en   = 1'b1;
          bus.csr_write_addr = ADDR_MCAUSE;
          bus.csr_data_write = cause_q;
`ifdef CSR_MTVAL_EN
          state_d            = T_TVAL;
`else
          state_d            = T_VEC;
`endif
        end
`ifdef CSR_MTVAL_EN
        T_TVAL: begin
          bus.csr_write_en   = 1'b1;
          bus.csr_write_addr = ADDR_MTVAL;
          bus.csr_data_write = tval_q;
          state_d            = T_VEC;
        end
`endif
        T_VEC: begin
          bus.csr_read_addr = ADDR_MTVEC;
          bus.redir_valid   = 1'b1;
          bus.redir_pc      = vec_target;
          state_d           = IDLE;
        end
        M_RD: begin
          bus.csr_read_addr = ADDR_MEPC;
          bus.redir_valid   = 1'b1;
          bus.redir_pc      = bus.csr_data_read;
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: vector table for CSR instructions plus trap/mret/reset sequences.
module tb_csr_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_access_ctrl_if bus();

  csr_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Regfile model: combinational read, posedge write, plus a preload port for the bench.
  logic [31:0] regs [0:4095] = '{default: '0};
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign bus.csr_data_read = regs[bus.csr_read_addr];

  always @(posedge clk) begin
    if (bus.csr_write_en) regs[bus.csr_write_addr] <= bus.csr_data_write;
    if (pre_en) regs[pre_addr] <= pre_data;
  end

`ifdef CSR_MTVAL_EN
  localparam int TRAP_LAT = 4;
`else
  localparam int TRAP_LAT = 3;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        zero;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t        vecs [10];
  logic [43:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and score any regfile write seen in that cycle.
  task automatic tick();
    @(negedge clk);
    if (bus.csr_write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'h0, bus.csr_write_addr, bus.csr_data_write}, 64'h0);
      end else begin
        check("write", {20'h0, bus.csr_write_addr, bus.csr_data_write}, {20'h0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    preload(v.addr, v.pre);
    if (v.exp_we) exp_q.push_back({v.addr, v.exp_wdata});
    bus.ins_valid    = 1'b1;
    bus.ins_op       = v.op;
    bus.ins_addr     = v.addr;
    bus.ins_src      = v.src;
    bus.ins_src_zero = v.zero;
    #1;
    check("ins_ready_idle", bus.ins_ready, 1);
    tick();
    bus.ins_valid    = 1'b0;
    bus.ins_op       = 3'($urandom_range(0, 7));
    bus.ins_addr     = 12'($urandom());
    bus.ins_src      = $urandom();
    bus.ins_src_zero = 1'($urandom_range(0, 1));
    check("rsp_not_early", bus.rsp_valid, 0);
    tick();
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_illegal", bus.rsp_illegal, v.exp_ill);
    tick();
    check("rsp_pulse_end", bus.rsp_valid, 0);
    check("reg_final", regs[v.addr], v.exp_we ? v.exp_wdata : v.pre);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{3'b001, 12'h305, 32'h80000101, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h80000101};
    vecs[1] = '{3'b010, 12'h305, 32'h00000000, 1'b1, 32'h80000101, 32'h80000101, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{3'b011, 12'h340, 32'h0000000F, 1'b0, 32'h000000FF, 32'h000000FF, 1'b0, 1'b1, 32'h000000F0};
    vecs[3] = '{3'b110, 12'h340, 32'h00000010, 1'b0, 32'h000000F0, 32'h000000F0, 1'b0, 1'b1, 32'h000000F0};
    vecs[4] = '{3'b100, 12'h340, 32'h00000005, 1'b0, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{3'b000, 12'h300, 32'h00000007, 1'b0, 32'h0000ABCD, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{3'b101, 12'h300, 32'h0000001F, 1'b0, 32'hAAAA5555, 32'hAAAA5555, 1'b0, 1'b1, 32'h0000001F};
    vecs[7] = '{3'b111, 12'h300, 32'h00000000, 1'b1, 32'h0000001F, 32'h0000001F, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{3'b010, 12'h341, 32'h00000003, 1'b0, 32'h00001000, 32'h00001000, 1'b0, 1'b1, 32'h00001003};
    vecs[9] = '{3'b001, 12'h342, 32'h00000000, 1'b1, 32'h00000055, 32'h00000055, 1'b0, 1'b1, 32'h00000000};

    bus.ins_valid = 0; bus.ins_op = 0; bus.ins_addr = 0; bus.ins_src = 0; bus.ins_src_zero = 0;
    bus.trap_valid = 0; bus.trap_pc = 0; bus.trap_cause = 0; bus.trap_tval = 0; bus.mret_valid = 0;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_state", bus.dbg_state, 0);
    check("rst_trap_ready", bus.trap_ready, 0);
    check("rst_write_en", bus.csr_write_en, 0);
    check("rst_redir", bus.redir_valid, 0);
    check("rst_rsp", bus.rsp_valid, 0);
    rst = 1'b1;
    #1;
    check("idle_trap_ready", bus.trap_ready, 1);
    check("idle_mret_ready", bus.mret_ready, 1);
    check("idle_ins_ready", bus.ins_ready, 1);
    check("idle_read_addr", bus.csr_read_addr, 0);
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Trap, mret and instruction all requested together
    preload(12'h305, 32'h00000201);
    bus.trap_valid = 1; bus.trap_pc = 32'h00001006; bus.trap_cause = 32'h8000000B;
    bus.trap_tval = 32'hDEADBEEF; bus.mret_valid = 1;
    bus.ins_valid = 1; bus.ins_op = 3'b010; bus.ins_addr = 12'h342; bus.ins_src = 0; bus.ins_src_zero = 1;
    #1;
    check("prio_trap_ready", bus.trap_ready, 1);
    check("prio_mret_ready", bus.mret_ready, 0);
    check("prio_ins_ready", bus.ins_ready, 0);
    exp_q.push_back({12'h341, 32'h00001004});
    exp_q.push_back({12'h342, 32'h8000000B});
`ifdef CSR_MTVAL_EN
    exp_q.push_back({12'h343, 32'hDEADBEEF});
`endif
    tick();
    bus.trap_valid = 0; bus.trap_pc = $urandom(); bus.trap_cause = $urandom(); bus.trap_tval = $urandom();
    check("busy_mret_ready", bus.mret_ready, 0);
    cnt = 1;
    while (!bus.redir_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    check("trap_redir_latency", cnt, TRAP_LAT);
    check("trap_redir_pc", bus.redir_pc, 32'h0000022C);
    tick();
    check("redir_pulse_end", bus.redir_valid, 0);
    check("mret_ready_after_trap", bus.mret_ready, 1);
    check("ins_wait_mret", bus.ins_ready, 0);
    tick();
    bus.mret_valid = 0;
    check("mret_redir_valid", bus.redir_valid, 1);
    check("mret_redir_pc", bus.redir_pc, 32'h00001004);
    tick();
    check("ins_ready_after_mret", bus.ins_ready, 1);
    tick();
    bus.ins_valid = 0;
    tick();
    check("held_ins_rsp", bus.rsp_valid, 1);
    check("held_ins_rdata", bus.rsp_rdata, 32'h8000000B);
    tick();

    // Reset while mcause write is pending
    preload(12'h342, 32'h00001111);
    exp_q.push_back({12'h341, 32'h00002000});
    bus.trap_valid = 1; bus.trap_pc = 32'h00002003; bus.trap_cause = 32'h00000007;
    tick();
    bus.trap_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("abort_state_tcause", bus.dbg_state, 4);
    check("abort_write_en", bus.csr_write_en, 0);
    tick();
    check("abort_state_idle", bus.dbg_state, 0);
    check("abort_redir", bus.redir_valid, 0);
    check("abort_trap_ready", bus.trap_ready, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_redir", bus.redir_valid, 0);
    end
    check("abort_mepc_kept", regs[12'h341], 32'h00002000);
    check("abort_mcause_kept", regs[12'h342], 32'h00001111);

`ifdef CSR_MTVAL_EN
    check("mtval_written", regs[12'h343], 32'hDEADBEEF);
`else
    check("mtval_untouched", regs[12'h343], 32'h0);
`endif
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
